branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, program-counter width in bits.
REQ-002 SHALL have parameter INDEX_WIDTH, default 10, entry count 2**INDEX_WIDTH.
REQ-003 SHALL have parameter TAG_WIDTH, default 8, stored tag bits; 2+INDEX_WIDTH+TAG_WIDTH <= PC_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port lk_pc  input  PC_WIDTH  fetch PC to predict.
REQ-007 SHALL have port lk_hold  input  1  hold lookup outputs (fetch stall).
REQ-008 SHALL have port pred_hit  output  1  tagged entry found for last lookup.
REQ-009 SHALL have port pred_taken  output  1  predicted taken.
REQ-010 SHALL have port pred_target  output  PC_WIDTH  next-fetch PC.
REQ-011 SHALL have port up_valid  input  1  resolved instruction update strobe.
REQ-012 SHALL have port up_pc  input  PC_WIDTH  PC of resolved instruction.
REQ-013 SHALL have port up_branch  input  1  resolved instruction is branch/jump.
REQ-014 SHALL have port up_taken  input  1  actual outcome taken.
REQ-015 SHALL have port up_target  input  PC_WIDTH  actual taken target.
REQ-016 SHALL have port flush  input  1  invalidate all entries.

Function
REQ-017 SHALL index by pc[2 +: INDEX_WIDTH], tag by pc[2+INDEX_WIDTH +: TAG_WIDTH]; entry = {valid, tag, target, ctr[1:0]}.
REQ-018 SHALL register lookup outputs one cycle after lk_pc is presented (latency 1), matching synchronous imem read.
REQ-019 SHALL set pred_hit = valid && tag match; pred_taken = pred_hit && taken-decision (REQ-031).
REQ-020 SHALL drive pred_target = stored target if pred_taken, else lk_pc+4 (mod 2**PC_WIDTH, wrap silently).
REQ-021 SHALL keep all three lookup outputs unchanged while lk_hold=1; lk_pc ignored.
REQ-022 SHALL, on up_valid && up_branch && hit: ctr saturating +1 if up_taken, -1 if not; target <= up_target when up_taken.
REQ-023 SHALL saturate ctr at 2'b11 and 2'b00; no wrap.
REQ-024 SHALL, on up_valid && up_branch && miss && up_taken: allocate (replace) entry, tag/target written, ctr=2'b10.
REQ-025 SHALL NOT allocate on miss && !up_taken.
REQ-026 SHALL, on up_valid && !up_branch && hit: clear entry valid (alias removal).
REQ-027 SHALL, when update and lookup address same index same cycle, return post-update entry (write-first bypass).
REQ-028 SHALL clear every valid bit in the cycle flush=1; flush beats simultaneous update; lookup that cycle returns miss.
REQ-029 SHALL treat up_valid=0 as no state change regardless of other update inputs.

Reset
REQ-030 SHALL, while rst=1, asynchronously force pred_hit=0, pred_taken=0, pred_target=0, all valid bits=0; target/tag storage need not reset; first lookup after rst deassert misses.

Configuration
REQ-031 SHALL compile 2-bit counters when macro BPRED_COUNTER_EN is defined: taken-decision = ctr[1]; without it ctr is absent, taken-decision = 1 (hit means taken), miss-taken allocates, hit-not-taken clears valid.

Verification
REQ-032 SHALL cover: reset, lk_pc=0x100 -> next cycle pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-033 SHALL cover: update pc=0x100 taken target=0x200, then lk_pc=0x100 -> pred_hit=1, pred_taken=1, pred_target=0x200.
REQ-034 SHALL cover (BPRED_COUNTER_EN): after REQ-033, two not-taken updates at 0x100 -> pred_hit=1, pred_taken=0, pred_target=0x104; three taken updates -> ctr=2'b11, one not-taken -> still taken.
REQ-035 SHALL cover: entry at 0x100, lookup 0x100+(4<<INDEX_WIDTH) (same index, different tag) -> pred_hit=0, target=pc+4.
REQ-036 SHALL cover: flush and taken update at 0x300 same cycle -> lookup 0x300 misses; lk_hold=1 for 3 cycles -> outputs stable.
REQ-037 SHALL cover: rst asserted mid-stream between clock edges -> outputs 0 immediately, all prior entries miss after release.

Source files
------------

// File: rtl/bp_if.sv
// Lookup/update bus between fetch/resolve logic and the branch predictor.
interface bp_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] lk_pc;
    logic                lk_hold;
    logic                pred_hit;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
    logic                up_valid;
    logic [PC_WIDTH-1:0] up_pc;
    logic                up_branch;
    logic                up_taken;
    logic [PC_WIDTH-1:0] up_target;
    logic                flush;

    modport master (
        output lk_pc, lk_hold, up_valid, up_pc, up_branch, up_taken, up_target, flush,
        input  pred_hit, pred_taken, pred_target
    );

    modport slave (
        input  lk_pc, lk_hold, up_valid, up_pc, up_branch, up_taken, up_target, flush,
        output pred_hit, pred_taken, pred_target
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped tagged BTB with 1-cycle registered lookup and write-first update bypass.
// Optional 2-bit saturating direction counters: define BPRED_COUNTER_EN.
module branch_predictor #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned INDEX_WIDTH = 10,
    parameter int unsigned TAG_WIDTH   = 8
) (
    input logic clk,
    input logic rst,
    bp_if.slave bus
);
    localparam int unsigned ENTRIES  = 1 << INDEX_WIDTH;
    localparam int unsigned IDX_LSB  = 2;
    localparam int unsigned TAG_LSB  = IDX_LSB + INDEX_WIDTH;

    logic [ENTRIES-1:0]   valid;
    logic [TAG_WIDTH-1:0] tag_mem    [ENTRIES];
    logic [PC_WIDTH-1:0]  target_mem [ENTRIES];
`ifdef BPRED_COUNTER_EN
    logic [1:0]           ctr_mem    [ENTRIES];
    logic [1:0]           wr_ctr;
    logic [1:0]           lk_ctr;
`endif

    logic [INDEX_WIDTH-1:0] up_idx, lk_idx;
    logic [TAG_WIDTH-1:0]   up_tag, lk_tag;
    logic                   up_hit;

    logic                   wr_en;
    logic                   wr_valid;
    logic [TAG_WIDTH-1:0]   wr_tag;
    logic [PC_WIDTH-1:0]    wr_target;

    logic                   lk_valid;
    logic [TAG_WIDTH-1:0]   lk_stored_tag;
    logic [PC_WIDTH-1:0]    lk_stored_target;
    logic                   lk_hit_c, lk_taken_c;
    logic [PC_WIDTH-1:0]    lk_target_c;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lk_pc, bus.up_pc};

    assign up_idx = bus.up_pc[IDX_LSB +: INDEX_WIDTH];
    assign up_tag = bus.up_pc[TAG_LSB +: TAG_WIDTH];
    assign lk_idx = bus.lk_pc[IDX_LSB +: INDEX_WIDTH];
    assign lk_tag = bus.lk_pc[TAG_LSB +: TAG_WIDTH];
    assign up_hit = valid[up_idx] && (tag_mem[up_idx] == up_tag);

    // Resolve-side entry update; flush suppresses any concurrent update.
    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid[up_idx];
        wr_tag    = up_tag;
        wr_target = target_mem[up_idx];
`ifdef BPRED_COUNTER_EN
        wr_ctr    = ctr_mem[up_idx];
`endif
        if (bus.up_valid && !bus.flush) begin
            if (bus.up_branch) begin
                if (up_hit) begin
`ifdef BPRED_COUNTER_EN
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    if (bus.up_taken) begin
                        wr_target = bus.up_target;
                        if (wr_ctr != 2'b11) wr_ctr = wr_ctr + 2'd1;
                    end else begin
                        if (wr_ctr != 2'b00) wr_ctr = wr_ctr - 2'd1;
                    end
`else
                    wr_en    = 1'b1;
                    wr_valid = bus.up_taken;
                    if (bus.up_taken) wr_target = bus.up_target;
`endif
                end else if (bus.up_taken) begin
                    wr_en     = 1'b1;
                    wr_valid  = 1'b1;
                    wr_target = bus.up_target;
`ifdef BPRED_COUNTER_EN
                    wr_ctr    = 2'b10;
`endif
                end
            end else if (up_hit) begin
                wr_en    = 1'b1;
                wr_valid = 1'b0;
            end
        end
    end

    // Lookup read with write-first forwarding from a same-index update.
    always_comb begin
        lk_valid         = valid[lk_idx];
        lk_stored_tag    = tag_mem[lk_idx];
        lk_stored_target = target_mem[lk_idx];
`ifdef BPRED_COUNTER_EN
        lk_ctr           = ctr_mem[lk_idx];
`endif
        if (wr_en && (up_idx == lk_idx)) begin
            lk_valid         = wr_valid;
            lk_stored_tag    = wr_tag;
            lk_stored_target = wr_target;
`ifdef BPRED_COUNTER_EN
            lk_ctr           = wr_ctr;
`endif
        end
        if (bus.flush) lk_valid = 1'b0;

        lk_hit_c = lk_valid && (lk_stored_tag == lk_tag);
`ifdef BPRED_COUNTER_EN
        lk_taken_c = lk_hit_c && lk_ctr[1];
`else
        lk_taken_c = lk_hit_c;
`endif
        lk_target_c = lk_taken_c ? lk_stored_target : (bus.lk_pc + PC_WIDTH'(4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (bus.flush) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[up_idx] <= wr_valid;
        end
    end

    // Payload storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[up_idx]    <= wr_tag;
            target_mem[up_idx] <= wr_target;
`ifdef BPRED_COUNTER_EN
            ctr_mem[up_idx]    <= wr_ctr;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.pred_hit    <= 1'b0;
            bus.pred_taken  <= 1'b0;
            bus.pred_target <= '0;
        end else if (!bus.lk_hold) begin
            bus.pred_hit    <= lk_hit_c;
            bus.pred_taken  <= lk_taken_c;
            bus.pred_target <= lk_target_c;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (either counter configuration).
module tb_branch_predictor;
    localparam int unsigned PC_WIDTH    = 32;
    localparam int unsigned INDEX_WIDTH = 10;
    localparam int unsigned TAG_WIDTH   = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bp_if #(.PC_WIDTH(PC_WIDTH)) bus ();

    branch_predictor #(
        .PC_WIDTH(PC_WIDTH), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic hit, input logic taken,
                              input logic [PC_WIDTH-1:0] target);
        logic [PC_WIDTH+1:0] obs;
        logic [PC_WIDTH+1:0] exp;
        obs = {bus.pred_hit, bus.pred_taken, bus.pred_target};
        exp = {hit, taken, target};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed hit/taken/target=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [PC_WIDTH-1:0] pc, input logic br, input logic tk,
                       input logic [PC_WIDTH-1:0] tgt);
        bus.up_valid  = 1'b1;
        bus.up_pc     = pc;
        bus.up_branch = br;
        bus.up_taken  = tk;
        bus.up_target = tgt;
    endtask

    task automatic noupd();
        bus.up_valid = 1'b0;
    endtask

    // Present an update and a lookup in the same cycle, then check the lookup result.
    task automatic step_chk(input string tag, input logic [PC_WIDTH-1:0] pc, input logic tk,
                            input logic exp_taken, input logic [PC_WIDTH-1:0] exp_tgt);
        upd(pc, 1'b1, tk, 32'h200);
        bus.lk_pc = pc;
        cyc();
        expect_out(tag, 1'b1, exp_taken, exp_tgt);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b0;
        bus.lk_pc     = '0;
        bus.lk_hold   = 1'b0;
        bus.up_valid  = 1'b0;
        bus.up_pc     = '0;
        bus.up_branch = 1'b0;
        bus.up_taken  = 1'b0;
        bus.up_target = '0;
        bus.flush     = 1'b0;

        #2 rst = 1'b1;
        cyc();
        expect_out("reset_state", 1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        bus.lk_pc = 32'h100;
        cyc();
        expect_out("first_lookup_miss", 1'b0, 1'b0, 32'h104);

        // Allocate with same-cycle lookup exercises write-first forwarding.
        upd(32'h100, 1'b1, 1'b1, 32'h200);
        cyc();
        expect_out("alloc_bypass", 1'b1, 1'b1, 32'h200);
        noupd();
        cyc();
        expect_out("alloc_stored", 1'b1, 1'b1, 32'h200);

`ifdef BPRED_COUNTER_EN
        step_chk("ctr_nt1",      32'h100, 1'b0, 1'b0, 32'h104);
        step_chk("ctr_nt2",      32'h100, 1'b0, 1'b0, 32'h104);
        step_chk("ctr_sat_low",  32'h100, 1'b0, 1'b0, 32'h104);
        step_chk("ctr_t1",       32'h100, 1'b1, 1'b0, 32'h104);
        step_chk("ctr_t2",       32'h100, 1'b1, 1'b1, 32'h200);
        step_chk("ctr_t3",       32'h100, 1'b1, 1'b1, 32'h200);
        step_chk("ctr_sat_high", 32'h100, 1'b1, 1'b1, 32'h200);
        step_chk("ctr_nt_still", 32'h100, 1'b0, 1'b1, 32'h200);
        step_chk("ctr_nt_weak",  32'h100, 1'b0, 1'b0, 32'h104);
        step_chk("ctr_t_back",   32'h100, 1'b1, 1'b1, 32'h200);
`else
        upd(32'h100, 1'b1, 1'b0, 32'h0);
        cyc();
        expect_out("hit_nt_clears", 1'b0, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 1'b1, 32'h200);
        cyc();
        expect_out("realloc", 1'b1, 1'b1, 32'h200);
`endif
        noupd();

        upd(32'h500, 1'b1, 1'b0, 32'h900);
        cyc();
        noupd();
        bus.lk_pc = 32'h500;
        cyc();
        expect_out("miss_nt_no_alloc", 1'b0, 1'b0, 32'h504);

        bus.lk_pc = 32'h100 + (32'd4 << INDEX_WIDTH);
        cyc();
        expect_out("alias_tag_miss", 1'b0, 1'b0, 32'h1104);

        upd(32'h600, 1'b1, 1'b1, 32'h700);
        bus.lk_pc = 32'h600;
        cyc();
        noupd();
        cyc();
        expect_out("alloc_600", 1'b1, 1'b1, 32'h700);
        upd(32'h600, 1'b0, 1'b0, 32'h0);
        cyc();
        expect_out("nonbranch_clears", 1'b0, 1'b0, 32'h604);

        bus.up_valid  = 1'b0;
        bus.up_pc     = 32'h100;
        bus.up_branch = 1'b0;
        bus.lk_pc     = 32'h100;
        cyc();
        expect_out("upvalid0_no_change", 1'b1, 1'b1, 32'h200);

        // Flush wins over a same-cycle allocate; lookup that cycle misses.
        bus.flush = 1'b1;
        upd(32'h300, 1'b1, 1'b1, 32'h400);
        bus.lk_pc = 32'h100;
        cyc();
        expect_out("flush_cycle_miss", 1'b0, 1'b0, 32'h104);
        bus.flush = 1'b0;
        noupd();
        bus.lk_pc = 32'h300;
        cyc();
        expect_out("flush_beats_update", 1'b0, 1'b0, 32'h304);
        bus.lk_pc = 32'h100;
        cyc();
        expect_out("flush_cleared_100", 1'b0, 1'b0, 32'h104);

        upd(32'h300, 1'b1, 1'b1, 32'h400);
        cyc();
        noupd();
        bus.lk_pc = 32'h300;
        cyc();
        expect_out("alloc_300", 1'b1, 1'b1, 32'h400);
        bus.lk_hold = 1'b1;
        bus.lk_pc   = 32'h800;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_out($sformatf("hold_%0d", i), 1'b1, 1'b1, 32'h400);
        end
        bus.lk_hold = 1'b0;
        cyc();
        expect_out("hold_release", 1'b0, 1'b0, 32'h804);

        bus.lk_pc = 32'hFFFF_FFFC;
        cyc();
        expect_out("pc_wrap", 1'b0, 1'b0, 32'h0);

        bus.lk_pc = 32'h300;
        cyc();
        expect_out("pre_reset_hit", 1'b1, 1'b1, 32'h400);
        #3 rst = 1'b1;
        #1;
        expect_out("async_reset_now", 1'b0, 1'b0, 32'h0);
        cyc();
        rst = 1'b0;
        cyc();
        expect_out("post_reset_300", 1'b0, 1'b0, 32'h304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
